// File: rtl/hist_pkg.sv
// hist_pkg: shared types and constants for the histogram sequencer.
//   state_e     - sequencer state encoding
//   BINS        - number of histogram bins (2**PIX_W)
//   PIX_W/CNT_W - default pixel and bin-counter widths
//   CNT_MAX     - saturated bin count
//   OUT_*       - field positions inside the {bin, count} output word
package hist_pkg;

  localparam int PIX_W      = 8;
  localparam int CNT_W      = 24;
  localparam int BINS       = 2 ** PIX_W;
  localparam int PIXELS_DEF = 76800;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // out word = {bin index, count}; count occupies the low CNT_W bits
  localparam int OUT_CNT_LSB = 0;
  localparam int OUT_BIN_LSB = CNT_W;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACC_RD,
    ACC_WR,
    DMP_RD,
    DMP_CAP,
    DMP_OUT,
    DONE
  } state_e;

endpackage

// File: rtl/hist_sat_inc.sv
// hist_sat_inc: combinational W-bit saturating adder.
//   a_i, b_i - operands
//   sum_o    - a_i + b_i, clamped to all-ones on overflow
// Used with b_i = 1 as the bin increment, and as the running-sum adder
// when HIST_CDF_EN is defined.
module hist_sat_inc
  import hist_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic [W:0] full;

  assign full  = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/histogram_seq_ctrl.sv
// histogram_seq_ctrl: CLEAR -> ACCUMULATE -> DUMP sequencer for a 2**PIX_W bin
// histogram held in an external single-port RAM with 1-cycle read latency.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i                      frame start, honoured only in IDLE/DONE
//   pix_valid_i/pix_data_i/pix_ready_o   pixel stream in
//   ram_addr_o/ram_we_o/ram_wdata_o/ram_rdata_i   bin RAM port
//   out_valid_o/out_data_o/out_ready_i   {bin, count} stream out
//   busy_o, done_o               status
// Build option: HIST_CDF_EN - dump emits cumulative (saturating) counts.
//
// state   | meaning
// IDLE    | waiting for start after reset
// CLEAR   | writing zero to bin k, one bin per cycle
// ACC_RD  | pixel ready, bin RAM read issued at the pixel value
// ACC_WR  | saturating increment written back to the latched pixel's bin
// DMP_RD  | bin RAM read issued at bin k
// DMP_CAP | read data captured into the output word
// DMP_OUT | output word held until accepted
// DONE    | histogram complete; RAM holds the result
module histogram_seq_ctrl #(
  parameter int PIXELS = hist_pkg::PIXELS_DEF,
  parameter int PIX_W  = hist_pkg::PIX_W,
  parameter int CNT_W  = hist_pkg::CNT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   pix_valid_i,
  input  logic [PIX_W-1:0]       pix_data_i,
  output logic                   pix_ready_o,
  output logic [PIX_W-1:0]       ram_addr_o,
  output logic                   ram_we_o,
  output logic [CNT_W-1:0]       ram_wdata_o,
  input  logic [CNT_W-1:0]       ram_rdata_i,
  output logic                   out_valid_o,
  output logic [PIX_W+CNT_W-1:0] out_data_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic                   done_o
);
  import hist_pkg::*;

  localparam int PC_W = $clog2(PIXELS + 1);
  localparam logic [PIX_W-1:0] K_LAST = '1;

  state_e                   state_q;
  logic [PIX_W-1:0]         k_q;
  logic [PIX_W-1:0]         pix_q;
  logic [PC_W-1:0]          pix_cnt_q;
  logic                     out_valid_q;
  logic [PIX_W+CNT_W-1:0]   out_data_q;
  logic                     done_q;

  logic [CNT_W-1:0]         inc_cnt_d;
  logic [CNT_W-1:0]         cap_cnt_d;

  hist_sat_inc #(.W(CNT_W)) u_inc (
    .a_i   (ram_rdata_i),
    .b_i   (CNT_W'(1)),
    .sum_o (inc_cnt_d)
  );

`ifdef HIST_CDF_EN
  logic [CNT_W-1:0] sum_q;
  logic [CNT_W-1:0] sum_base;

  // running sum restarts at bin 0 so each dump is self-contained
  assign sum_base = (k_q == '0) ? '0 : sum_q;

  hist_sat_inc #(.W(CNT_W)) u_cdf_add (
    .a_i   (sum_base),
    .b_i   (ram_rdata_i),
    .sum_o (cap_cnt_d)
  );
`else
  assign cap_cnt_d = ram_rdata_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      k_q         <= '0;
      pix_q       <= '0;
      pix_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
`ifdef HIST_CDF_EN
      sum_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q <= CLEAR;
            k_q     <= '0;
            done_q  <= 1'b0;
          end
        end
        CLEAR: begin
          // k wraps back to 0 after the last bin, ready for the dump later
          k_q <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            state_q   <= ACC_RD;
            pix_cnt_q <= '0;
          end
        end
        ACC_RD: begin
          if (pix_valid_i) begin
            pix_q   <= pix_data_i;
            state_q <= ACC_WR;
          end
        end
        ACC_WR: begin
          pix_cnt_q <= pix_cnt_q + 1'b1;
          if (pix_cnt_q == PC_W'(PIXELS - 1)) begin
            state_q <= DMP_RD;
            k_q     <= '0;
          end else begin
            state_q <= ACC_RD;
          end
        end
        DMP_RD: begin
          state_q <= DMP_CAP;
        end
        DMP_CAP: begin
          out_data_q  <= {k_q, cap_cnt_d};
          out_valid_q <= 1'b1;
          state_q     <= DMP_OUT;
`ifdef HIST_CDF_EN
          sum_q       <= cap_cnt_d;
`endif
        end
        DMP_OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (k_q == K_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              k_q     <= k_q + 1'b1;
              state_q <= DMP_RD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM port is decoded from state: the accumulate read address must follow
  // the incoming pixel in the same cycle to meet the 1-cycle read latency.
  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_wdata_o = '0;
    case (state_q)
      CLEAR: begin
        ram_addr_o = k_q;
        ram_we_o   = 1'b1;
      end
      ACC_RD:  ram_addr_o = pix_data_i;
      ACC_WR: begin
        ram_addr_o  = pix_q;
        ram_we_o    = 1'b1;
        ram_wdata_o = inc_cnt_d;
      end
      DMP_RD, DMP_CAP: ram_addr_o = k_q;
      default: ;
    endcase
  end

  assign pix_ready_o = (state_q == ACC_RD);
  assign busy_o      = (state_q != IDLE) && (state_q != DONE);
  assign done_o      = done_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_histogram_seq_ctrl.sv
module tb_histogram_seq_ctrl;
  import hist_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance: 8-pixel frames, 24-bit counts
  logic        a_start = 0, a_pix_valid = 0, a_out_ready = 0;
  logic [7:0]  a_pix_data = 0;
  logic        a_pix_ready, a_ram_we, a_out_valid, a_busy, a_done;
  logic [7:0]  a_ram_addr;
  logic [23:0] a_ram_wdata, a_ram_rdata;
  logic [31:0] a_out_data;
  logic [23:0] mem_a [256];

  // narrow instance: 2-bit counts for saturation
  logic        s_start = 0, s_pix_valid = 0, s_out_ready = 0;
  logic [7:0]  s_pix_data = 0;
  logic        s_pix_ready, s_ram_we, s_out_valid, s_busy, s_done;
  logic [7:0]  s_ram_addr;
  logic [1:0]  s_ram_wdata, s_ram_rdata;
  logic [9:0]  s_out_data;
  logic [1:0]  mem_s [256];

  histogram_seq_ctrl #(.PIXELS(8), .PIX_W(8), .CNT_W(24)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start),
    .pix_valid_i(a_pix_valid), .pix_data_i(a_pix_data), .pix_ready_o(a_pix_ready),
    .ram_addr_o(a_ram_addr), .ram_we_o(a_ram_we), .ram_wdata_o(a_ram_wdata),
    .ram_rdata_i(a_ram_rdata),
    .out_valid_o(a_out_valid), .out_data_o(a_out_data), .out_ready_i(a_out_ready),
    .busy_o(a_busy), .done_o(a_done));

  histogram_seq_ctrl #(.PIXELS(5), .PIX_W(8), .CNT_W(2)) u_s (
    .clk_i(clk), .rst_i(rst), .start_i(s_start),
    .pix_valid_i(s_pix_valid), .pix_data_i(s_pix_data), .pix_ready_o(s_pix_ready),
    .ram_addr_o(s_ram_addr), .ram_we_o(s_ram_we), .ram_wdata_o(s_ram_wdata),
    .ram_rdata_i(s_ram_rdata),
    .out_valid_o(s_out_valid), .out_data_o(s_out_data), .out_ready_i(s_out_ready),
    .busy_o(s_busy), .done_o(s_done));

  always_ff @(posedge clk) begin
    if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
    a_ram_rdata <= mem_a[a_ram_addr];
    if (s_ram_we) mem_s[s_ram_addr] <= s_ram_wdata;
    s_ram_rdata <= mem_s[s_ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  frame_px [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a();
    chk("rst_busy",   {31'b0, a_busy}, 0);
    chk("rst_done",   {31'b0, a_done}, 0);
    chk("rst_valid",  {31'b0, a_out_valid}, 0);
    chk("rst_we",     {31'b0, a_ram_we}, 0);
    chk("rst_ready",  {31'b0, a_pix_ready}, 0);
    chk("rst_data",   a_out_data, 0);
  endtask

  // model: per-bin counts (or running sum) saturating at 2**w-1
  task automatic push_expected(input int h[256], input int w, input bit cdf);
    int sum, mx;
    mx = (1 << w) - 1;
    sum = 0;
    for (int b = 0; b < 256; b++) begin
      if (cdf) sum = (sum + h[b] > mx) ? mx : sum + h[b];
      else     sum = (h[b] > mx) ? mx : h[b];
      exp_q.push_back((32'(b) << w) | 32'(sum));
    end
  endtask

  task automatic feed_a(input logic [7:0] p, input int gap);
    int wait_cnt;
    a_pix_valid = 0;
    repeat (gap) @(negedge clk);
    a_pix_valid = 1;
    a_pix_data  = p;
    wait_cnt = 0;
    while (!a_pix_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("pix_accept_timeout", {31'b0, wait_cnt < 50}, 1);
    @(negedge clk);
    a_pix_valid = 0;
    chk("accwr_ready", {31'b0, a_pix_ready}, 0);
    chk("accwr_we",    {31'b0, a_ram_we}, 1);
    chk("accwr_addr",  {24'b0, a_ram_addr}, {24'b0, p});
  endtask

  task automatic dump_a(input bit stall);
    int cycles, stall_cnt;
    logic [31:0] e;
    cycles = 0;
    stall_cnt = 0;
    a_out_ready = 0;
    while (exp_q.size() > 0 && cycles < 1200) begin
      @(negedge clk);
      cycles++;
      if (a_out_valid) begin
        if (stall && a_out_data[OUT_BIN_LSB +: 8] == 8'd3 && stall_cnt < 10) begin
          a_out_ready = 0;
          stall_cnt++;
          chk("stall_hold", a_out_data, exp_q[0]);
        end else begin
          a_out_ready = 1;
          e = exp_q.pop_front();
          chk("dump_word", a_out_data, e);
        end
      end
    end
    chk("dump_timeout", {31'b0, cycles < 1200}, 1);
    if (stall) chk("stall_cycles", stall_cnt, 10);
    exp_q.delete();
    @(negedge clk);
    a_out_ready = 0;
    chk("done_level", {31'b0, a_done}, 1);
    chk("done_busy",  {31'b0, a_busy}, 0);
    chk("done_valid", {31'b0, a_out_valid}, 0);
    chk("done_we",    {31'b0, a_ram_we}, 0);
  endtask

  task automatic run_frame_a(input bit gaps, input bit stall, input bit busy_start);
    int h[256];
    bit cdf;
`ifdef HIST_CDF_EN
    cdf = 1;
`else
    cdf = 0;
`endif
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    chk("start_busy", {31'b0, a_busy}, 1);
    chk("start_done_drop", {31'b0, a_done}, 0);
    for (int i = 0; i < 256; i++) begin
      chk("clear_addr",  {24'b0, a_ram_addr}, i);
      chk("clear_we",    {31'b0, a_ram_we}, 1);
      chk("clear_wdata", {8'b0, a_ram_wdata}, 0);
      @(negedge clk);
    end
    chk("acc_ready", {31'b0, a_pix_ready}, 1);
    chk("acc_we",    {31'b0, a_ram_we}, 0);
    foreach (h[b]) h[b] = 0;
    for (int i = 0; i < 8; i++) begin
      h[frame_px[i]]++;
      feed_a(frame_px[i], gaps ? (i % 6) : 0);
      if (busy_start && i == 3) begin
        a_start = 1;
        repeat (2) @(negedge clk);
        a_start = 0;
        chk("start_ignored_ready", {31'b0, a_pix_ready}, 1);
        chk("start_ignored_busy",  {31'b0, a_busy}, 1);
      end
    end
    push_expected(h, 24, cdf);
    dump_a(stall);
  endtask

  initial begin
    int h[256];
    int wait_cnt, cycles;
    logic [31:0] e;
    bit cdf;
`ifdef HIST_CDF_EN
    cdf = 1;
`else
    cdf = 0;
`endif

    // reset
    repeat (3) @(negedge clk);
    rst = 0;
    chk_reset_a();

    // frames 1/2/3: clear sweep, fixed pixels, stall at bin 3
    frame_px = '{8'd3, 8'd3, 8'd3, 8'd7, 8'd0, 8'd255, 8'd3, 8'd7};
    run_frame_a(0, 1, 0);

    // frame 4: gapped valid, restart from DONE, start ignored while busy
    run_frame_a(1, 0, 1);

    // frame 5: reset mid-accumulate, then a different frame
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    repeat (256) @(negedge clk);
    feed_a(8'd3, 0);
    feed_a(8'd100, 1);
    feed_a(8'd3, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_reset_a();
    frame_px = '{8'd1, 8'd1, 8'd2, 8'd200, 8'd200, 8'd200, 8'd50, 8'd9};
    run_frame_a(0, 0, 0);

    // narrow counter: five pixels of 9 saturate at 3
    s_start = 1;
    @(negedge clk);
    s_start = 0;
    chk("s_busy", {31'b0, s_busy}, 1);
    repeat (256) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      s_pix_valid = 1;
      s_pix_data  = 8'd9;
      wait_cnt = 0;
      while (!s_pix_ready && wait_cnt < 50) begin
        @(negedge clk);
        wait_cnt++;
      end
      chk("s_accept_timeout", {31'b0, wait_cnt < 50}, 1);
      @(negedge clk);
      s_pix_valid = 0;
    end
    foreach (h[b]) h[b] = 0;
    h[9] = 5;
    push_expected(h, 2, cdf);
    s_out_ready = 1;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 1200) begin
      @(negedge clk);
      cycles++;
      if (s_out_valid) begin
        e = exp_q.pop_front();
        chk("s_dump_word", {22'b0, s_out_data}, e);
      end
    end
    chk("s_dump_timeout", {31'b0, cycles < 1200}, 1);
    exp_q.delete();
    @(negedge clk);
    chk("s_done", {31'b0, s_done}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
